// File: rtl/cpu_pad_pkg.sv
// Shared types and constants for the CPU pad-ring host driver.
// The FSM state encoding and default pin widths live here so the top and bench agree.
package cpu_pad_pkg;

    localparam int unsigned ADDR_W_DEF = 32'd5;
    localparam int unsigned DATA_W_DEF = 32'd8;
    localparam int unsigned VOUT_W_DEF = 32'd2;
    localparam int unsigned EGG_W      = 32'd3;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        HOLD     = 3'd1,
        RUN      = 3'd2,
        SETTLE_S = 3'd3,
        OUT      = 3'd4,
        DONE     = 3'd5
    } state_e;

    // A window of n cycles is timed by loading n-1 and counting down to zero.
    function automatic int unsigned cycles_to_load(input int unsigned n);
        return (n > 32'd0) ? (n - 32'd1) : 32'd0;
    endfunction

endpackage

// File: rtl/cpu_pad_cycle_cnt.sv
// Loadable down-counter with a zero flag; times both the CPU run window and the
// vout_addr settle hold. A load takes priority over counting; the count sticks at zero.
module cpu_pad_cycle_cnt #(
    parameter int unsigned W = 32'd8
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         en_i,
    output logic         zero_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: load, decrement while enabled and non-zero, otherwise hold
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (en_i && (cnt_q != {W{1'b0}})) begin
            cnt_d = cnt_q - W'(1'b1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= {W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == {W{1'b0}});

endmodule

// File: rtl/cpu_pad_host.sv
// Host-side driver for the CPU pad ring: loads program/register beats while the CPU
// is held in reset, runs it for a fixed window, then reads back every output slot.
module cpu_pad_host
    import cpu_pad_pkg::*;
#(
    parameter int unsigned ADDR_W     = ADDR_W_DEF,
    parameter int unsigned DATA_W     = DATA_W_DEF,
    parameter int unsigned VOUT_W     = VOUT_W_DEF,
    parameter int unsigned RUN_CYCLES = 32'd64,
    parameter int unsigned SETTLE     = 32'd2
) (
    input  logic              clk_i,
    input  logic              resetn,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic              ld_is_data,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_byte,
    input  logic              ld_last,
    output logic              DataOrReg,
    output logic [ADDR_W-1:0] address,
    output logic [DATA_W-1:0] instr_i,
    output logic              reset,
    output logic [VOUT_W-1:0] vout_addr,
    input  logic [DATA_W-1:0] value_o,
    input  logic              is_positive,
    input  logic [EGG_W-1:0]  easter_egg,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [VOUT_W-1:0] rd_index,
    output logic [DATA_W-1:0] rd_value,
    output logic              rd_positive,
    output logic [EGG_W-1:0]  rd_egg,
    output logic              rd_last,
    output logic              busy,
    output logic              done
);

    localparam int unsigned CNT_MAX = (RUN_CYCLES > SETTLE) ? RUN_CYCLES : SETTLE;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 32'd1);

    localparam logic [CNT_W-1:0]  RUN_LOAD    = CNT_W'(cycles_to_load(RUN_CYCLES));
    localparam logic [CNT_W-1:0]  SETTLE_LOAD = CNT_W'(cycles_to_load(SETTLE));
    localparam logic [VOUT_W-1:0] VOUT_LAST   = {VOUT_W{1'b1}};

    state_e              state_q;
    logic                ld_ready_q;
    logic                last_q;
    logic                dor_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   instr_q;
    logic                reset_q;
    logic [VOUT_W-1:0]   vout_q;
    logic                rd_valid_q;
    logic [VOUT_W-1:0]   rd_index_q;
    logic [DATA_W-1:0]   rd_value_q;
    logic                rd_positive_q;
    logic [EGG_W-1:0]    rd_egg_q;
    logic                rd_last_q;
    logic                busy_q;
    logic                done_q;

    logic                cnt_load_s;
    logic [CNT_W-1:0]    cnt_val_s;
    logic                cnt_en_s;
    logic                cnt_zero_s;

    // Counter control: arm the run window leaving HOLD, and the settle hold on every new slot
    always_comb begin
        cnt_load_s = 1'b0;
        cnt_val_s  = SETTLE_LOAD;
        cnt_en_s   = 1'b0;
        case (state_q)
            HOLD: begin
                if (last_q) begin
                    cnt_load_s = 1'b1;
                    cnt_val_s  = RUN_LOAD;
                end else begin
                    cnt_load_s = 1'b0;
                end
            end
            RUN: begin
                cnt_en_s = 1'b1;
                if (cnt_zero_s) begin
                    cnt_load_s = 1'b1;
                end else begin
                    cnt_load_s = 1'b0;
                end
            end
            SETTLE_S: begin
                cnt_en_s = 1'b1;
            end
            OUT: begin
                if (rd_ready && !rd_last_q) begin
                    cnt_load_s = 1'b1;
                end else begin
                    cnt_load_s = 1'b0;
                end
            end
            default: begin
                cnt_load_s = 1'b0;
            end
        endcase
    end

    cpu_pad_cycle_cnt #(
        .W (CNT_W)
    ) u_cnt (
        .clk_i      (clk_i),
        .rst_ni     (resetn),
        .load_i     (cnt_load_s),
        .load_val_i (cnt_val_s),
        .en_i       (cnt_en_s),
        .zero_o     (cnt_zero_s)
    );

    // Sequencer; every pad pin and readback field is a register written only here
    always_ff @(posedge clk_i or negedge resetn) begin
        if (!resetn) begin
            state_q       <= IDLE;
            ld_ready_q    <= 1'b1;
            last_q        <= 1'b0;
            dor_q         <= 1'b0;
            addr_q        <= {ADDR_W{1'b0}};
            instr_q       <= {DATA_W{1'b0}};
            reset_q       <= 1'b1;
            vout_q        <= {VOUT_W{1'b0}};
            rd_valid_q    <= 1'b0;
            rd_index_q    <= {VOUT_W{1'b0}};
            rd_value_q    <= {DATA_W{1'b0}};
            rd_positive_q <= 1'b0;
            rd_egg_q      <= {EGG_W{1'b0}};
            rd_last_q     <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (ld_valid && ld_ready_q) begin
                        dor_q      <= ld_is_data;
                        addr_q     <= ld_addr;
                        instr_q    <= ld_byte;
                        last_q     <= ld_last;
                        ld_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                        state_q    <= HOLD;
                    end else begin
                        ld_ready_q <= 1'b1;
                        busy_q     <= 1'b0;
                    end
                end
                HOLD: begin
                    if (last_q) begin
                        reset_q <= 1'b0;
                        state_q <= RUN;
                    end else begin
                        ld_ready_q <= 1'b1;
                        busy_q     <= 1'b0;
                        state_q    <= IDLE;
                    end
                end
                RUN: begin
                    if (cnt_zero_s) begin
                        rd_egg_q <= easter_egg;
                        vout_q   <= {VOUT_W{1'b0}};
                        state_q  <= SETTLE_S;
                    end
                end
                SETTLE_S: begin
                    if (cnt_zero_s) begin
                        rd_value_q    <= value_o;
                        rd_positive_q <= is_positive;
                        rd_index_q    <= vout_q;
                        rd_last_q     <= (vout_q == VOUT_LAST);
                        rd_valid_q    <= 1'b1;
                        state_q       <= OUT;
                    end
                end
                OUT: begin
                    if (rd_ready) begin
                        rd_valid_q <= 1'b0;
                        if (rd_last_q) begin
                            done_q  <= 1'b1;
                            reset_q <= 1'b1;
                            vout_q  <= {VOUT_W{1'b0}};
                            state_q <= DONE;
                        end else begin
                            vout_q  <= vout_q + VOUT_W'(1'b1);
                            state_q <= SETTLE_S;
                        end
                    end
                end
                DONE: begin
                    done_q     <= 1'b0;
                    busy_q     <= 1'b0;
                    ld_ready_q <= 1'b1;
                    state_q    <= IDLE;
                end
                default: begin
                    state_q    <= IDLE;
                    reset_q    <= 1'b1;
                    ld_ready_q <= 1'b1;
                    rd_valid_q <= 1'b0;
                    busy_q     <= 1'b0;
                    done_q     <= 1'b0;
                end
            endcase
        end
    end

    assign ld_ready    = ld_ready_q;
    assign DataOrReg   = dor_q;
    assign address     = addr_q;
    assign instr_i     = instr_q;
    assign reset       = reset_q;
    assign vout_addr   = vout_q;
    assign rd_valid    = rd_valid_q;
    assign rd_index    = rd_index_q;
    assign rd_value    = rd_value_q;
    assign rd_positive = rd_positive_q;
    assign rd_egg      = rd_egg_q;
    assign rd_last     = rd_last_q;
    assign busy        = busy_q;
    assign done        = done_q;

endmodule

// File: tb/tb_cpu_pad_host.sv
// Scoreboard bench for cpu_pad_host: directed loads push expected readback beats,
// a negedge monitor pops and compares them and checks run/settle timing.
module tb_cpu_pad_host;

    localparam int RUN_CYCLES = 64;
    localparam int SETTLE     = 2;
    // easter_egg model below gives (64 mod 8) ^ 3'b101 on the last RUN cycle
    localparam logic [2:0] EGG_EXP = 3'd5;

    logic       clk_i = 1'b0;
    logic       resetn = 1'b1;
    logic       ld_valid = 1'b0, ld_ready, ld_is_data = 1'b0, ld_last = 1'b0;
    logic [4:0] ld_addr = 5'd0;
    logic [7:0] ld_byte = 8'd0;
    logic       DataOrReg, reset, is_positive;
    logic [4:0] address;
    logic [7:0] instr_i, value_o, rd_value;
    logic [1:0] vout_addr, rd_index;
    logic [2:0] easter_egg = 3'd7, rd_egg;
    logic       rd_valid, rd_ready = 1'b0, rd_positive, rd_last, busy, done;

    typedef struct packed {
        logic [1:0] idx;
        logic [7:0] val;
        logic       pos;
        logic       last;
        logic [2:0] egg;
    } beat_t;
    beat_t exp_q[$];

    int n_cmp = 0;
    int n_err = 0;
    int n_done = 0;

    always #5 clk_i = ~clk_i;

    cpu_pad_host #(
        .ADDR_W(5), .DATA_W(8), .VOUT_W(2), .RUN_CYCLES(RUN_CYCLES), .SETTLE(SETTLE)
    ) dut (
        .clk_i(clk_i), .resetn(resetn),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_is_data(ld_is_data),
        .ld_addr(ld_addr), .ld_byte(ld_byte), .ld_last(ld_last),
        .DataOrReg(DataOrReg), .address(address), .instr_i(instr_i), .reset(reset),
        .vout_addr(vout_addr), .value_o(value_o), .is_positive(is_positive),
        .easter_egg(easter_egg),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_index(rd_index),
        .rd_value(rd_value), .rd_positive(rd_positive), .rd_egg(rd_egg),
        .rd_last(rd_last), .busy(busy), .done(done)
    );

    // CPU model: static outputs keyed by the selected slot
    assign value_o     = 8'h10 + {6'b000000, vout_addr};
    assign is_positive = vout_addr[0];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // easter_egg changes every cycle the CPU runs, so only the right cycle gives EGG_EXP
    initial begin
        int run_k;
        run_k = 0;
        forever begin
            @(negedge clk_i);
            if (reset) begin
                run_k = 0;
                easter_egg = 3'd7;
            end else begin
                run_k = run_k + 1;
                easter_egg = 3'(run_k) ^ 3'b101;
            end
        end
    end

    // Monitor: scoreboard pops on handshake, plus stall, settle and window timing checks
    initial begin
        int    cyc, chg_cyc, pre_cnt;
        logic  seen_valid, prev_valid, prev_ready, prev_done;
        logic [7:0] prev_value;
        logic [1:0] prev_index, prev_vout;
        beat_t e;
        cyc = 0; chg_cyc = 0; pre_cnt = 0;
        seen_valid = 1'b0; prev_valid = 1'b0; prev_ready = 1'b0; prev_done = 1'b0;
        prev_value = 8'd0; prev_index = 2'd0; prev_vout = 2'd0;
        forever begin
            @(negedge clk_i);
            cyc++;
            if (!resetn) begin
                pre_cnt = 0; seen_valid = 1'b0; prev_valid = 1'b0;
                prev_ready = 1'b0; prev_done = 1'b0; prev_vout = 2'd0;
            end else begin
                if (vout_addr != prev_vout) chg_cyc = cyc;
                if (reset) begin
                    pre_cnt = 0;
                    seen_valid = 1'b0;
                end else if (!seen_valid) begin
                    if (rd_valid) begin
                        chk("run_window", 32'(pre_cnt), 32'(RUN_CYCLES + SETTLE));
                        seen_valid = 1'b1;
                    end else begin
                        pre_cnt++;
                    end
                end
                if (rd_valid && !prev_valid && rd_index != 2'd0)
                    chk("settle_delay", 32'(cyc - chg_cyc), 32'(SETTLE));
                if (prev_valid && !prev_ready) begin
                    chk("stall_valid", 32'(rd_valid), 32'd1);
                    chk("stall_value", 32'(rd_value), 32'(prev_value));
                    chk("stall_index", 32'(rd_index), 32'(prev_index));
                    chk("stall_vout", 32'(vout_addr), 32'(prev_vout));
                end
                if (rd_valid && rd_ready) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_beat", 32'(rd_index), 32'hFFFF_FFFF);
                    end else begin
                        e = exp_q.pop_front();
                        chk("beat_index", 32'(rd_index), 32'(e.idx));
                        chk("beat_value", 32'(rd_value), 32'(e.val));
                        chk("beat_positive", 32'(rd_positive), 32'(e.pos));
                        chk("beat_last", 32'(rd_last), 32'(e.last));
                        chk("beat_egg", 32'(rd_egg), 32'(e.egg));
                    end
                end
                if (done) begin
                    n_done++;
                    chk("reset_on_done", 32'(reset), 32'd1);
                    chk("vout_on_done", 32'(vout_addr), 32'd0);
                end
                if (prev_done) begin
                    chk("done_one_cycle", 32'(done), 32'd0);
                    chk("busy_after_done", 32'(busy), 32'd0);
                end
                prev_valid = rd_valid; prev_ready = rd_ready; prev_done = done;
                prev_value = rd_value; prev_index = rd_index; prev_vout = vout_addr;
            end
        end
    end

    task automatic chk_reset_state(input string tag);
        chk({tag, "_reset_pin"}, 32'(reset), 32'd1);
        chk({tag, "_ld_ready"}, 32'(ld_ready), 32'd1);
        chk({tag, "_pins"}, 32'({DataOrReg, address, instr_i, vout_addr}), 32'd0);
        chk({tag, "_rd_fields"},
            32'({rd_valid, rd_index, rd_value, rd_positive, rd_egg, rd_last}), 32'd0);
        chk({tag, "_busy_done"}, 32'({busy, done}), 32'd0);
    endtask

    task automatic push_run();
        beat_t e;
        for (int i = 0; i < 4; i++) begin
            e.idx  = 2'(i);
            e.val  = 8'h10 + 8'(i);
            e.pos  = (i % 2) == 1;
            e.last = (i == 3);
            e.egg  = EGG_EXP;
            exp_q.push_back(e);
        end
    endtask

    // Entered just after a rising edge with the DUT in IDLE; ld_valid stays high between beats
    task automatic send_beat(input logic d, input logic [4:0] a, input logic [7:0] b,
                             input logic last);
        chk("ld_ready_idle", 32'(ld_ready), 32'd1);
        chk("reset_in_load", 32'(reset), 32'd1);
        ld_valid = 1'b1; ld_is_data = d; ld_addr = a; ld_byte = b; ld_last = last;
        if (last) push_run();
        @(posedge clk_i); #1;
        chk("ld_ready_hold", 32'(ld_ready), 32'd0);
        chk("pins_hold", 32'({DataOrReg, address, instr_i}), 32'({d, a, b}));
        chk("reset_hold", 32'(reset), 32'd1);
        chk("busy_hold", 32'(busy), 32'd1);
        @(posedge clk_i); #1;
        chk("pins_after_hold", 32'({DataOrReg, address, instr_i}), 32'({d, a, b}));
        chk("reset_after_hold", 32'(reset), 32'(!last));
        if (last) begin
            ld_valid = 1'b0;
            chk("ld_ready_run", 32'(ld_ready), 32'd0);
        end
    endtask

    task automatic wait_valid(input int budget);
        for (int i = 0; i < budget && !rd_valid; i++) begin
            @(posedge clk_i); #1;
        end
        if (!rd_valid) chk("wait_valid_timeout", 32'(rd_valid), 32'd1);
    endtask

    task automatic wait_done(input int budget);
        for (int i = 0; i < budget && !done; i++) begin
            @(posedge clk_i); #1;
        end
        if (!done) chk("wait_done_timeout", 32'(done), 32'd1);
        @(posedge clk_i); #1;
    endtask

    task automatic run_program3();
        rd_ready = 1'b1;
        send_beat(1'b0, 5'd1, 8'h12, 1'b0);
        send_beat(1'b0, 5'd2, 8'h34, 1'b0);
        send_beat(1'b1, 5'd5, 8'h7F, 1'b1);
        wait_done(300);
        chk("idle_egg_held", 32'(rd_egg), 32'(EGG_EXP));
        chk("idle_pins_kept", 32'({DataOrReg, address, instr_i}), 32'({1'b1, 5'd5, 8'h7F}));
    endtask

    initial begin
        #1 resetn = 1'b0;
        #2 chk_reset_state("por");
        @(negedge clk_i) resetn = 1'b1;
        @(posedge clk_i); #1;

        // three-beat program, free-flowing readback
        run_program3();

        // readback stalled for 10 cycles on slot 1
        rd_ready = 1'b0;
        send_beat(1'b1, 5'd3, 8'hA5, 1'b1);
        wait_valid(200);
        rd_ready = 1'b1;
        @(posedge clk_i); #1;
        rd_ready = 1'b0;
        wait_valid(20);
        repeat (10) begin
            @(posedge clk_i); #1;
        end
        chk("stall_slot1_index", 32'(rd_index), 32'd1);
        rd_ready = 1'b1;
        wait_done(100);

        // abort with resetn while slot 2 is presented
        rd_ready = 1'b0;
        send_beat(1'b0, 5'd31, 8'hFF, 1'b1);
        wait_valid(200);
        for (int k = 0; k < 2; k++) begin
            rd_ready = 1'b1;
            @(posedge clk_i); #1;
            rd_ready = 1'b0;
            wait_valid(20);
        end
        chk("abort_at_slot2", 32'(rd_index), 32'd2);
        #1 resetn = 1'b0;
        #1 chk_reset_state("abort");
        chk("abort_outstanding", 32'(exp_q.size()), 32'd2);
        exp_q.delete();
        #4 resetn = 1'b1;
        @(posedge clk_i); #1;
        run_program3();

        // one-beat program goes HOLD -> RUN directly
        rd_ready = 1'b1;
        send_beat(1'b1, 5'd16, 8'h80, 1'b1);
        wait_done(300);

        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        chk("done_count", 32'(n_done), 32'd4);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/cpu_pad_host.md
Name: cpu_pad_host

Overview:
- Host-side driver for the CPU pad ring: the off-chip counterpart that drives the chip's input pads and reads back its output pads.
- Accepts program/register load beats on a valid/ready stream and drives them onto the DataOrReg/address/instr_i pins while holding the CPU in reset.
- Then releases reset for a fixed run window, walks vout_addr over all output slots, and returns each captured value_o/is_positive on a readback stream.
- Used in the FPGA test harness and as the bench driver for the padded top level.

Parameters:
ADDR_W, 5, width of address pins
DATA_W, 8, width of instr_i and value_o
VOUT_W, 2, width of vout_addr; readback slots = 2**VOUT_W
RUN_CYCLES, 64, cycles CPU runs out of reset before readback (>=1)
SETTLE, 2, cycles vout_addr is held stable before value_o is sampled (>=1)

Ports:
clk_i  in  1  clock, rising edge
resetn  in  1  asynchronous active-low reset
ld_valid  in  1  load beat valid
ld_ready  out  1  load beat accepted when ld_valid&ld_ready
ld_is_data  in  1  1=data memory, 0=register file (drives DataOrReg)
ld_addr  in  ADDR_W  target address
ld_byte  in  DATA_W  byte to write
ld_last  in  1  final load beat; starts run after it
DataOrReg  out  1  to CPU pad
address  out  ADDR_W  to CPU pad
instr_i  out  DATA_W  to CPU pad
reset  out  1  CPU reset, active high
vout_addr  out  VOUT_W  to CPU pad
value_o  in  DATA_W  from CPU pad
is_positive  in  1  from CPU pad
easter_egg  in  3  from CPU pad
rd_valid  out  1  readback beat valid
rd_ready  in  1  readback consumer ready
rd_index  out  VOUT_W  slot of this beat
rd_value  out  DATA_W  captured value_o
rd_positive  out  1  captured is_positive
rd_egg  out  3  easter_egg sampled at end of RUN; held through readback
rd_last  out  1  high on final slot beat
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse on DONE

Behaviour:
- Reset (resetn low, asynchronous): state IDLE; reset=1; DataOrReg=0, address=0, instr_i=0, vout_addr=0; rd_* =0; rd_valid=0; busy=0; done=0; all counters 0. Asserting mid-operation aborts immediately; no partial readback beat survives.
- All outputs are registered.
- IDLE:
  - reset=1, ld_ready=1.
  - On accept: register ld_is_data/ld_addr/ld_byte onto DataOrReg/address/instr_i at that edge; latch ld_last; go to HOLD.
- HOLD:
  - One cycle; ld_ready=0; pins unchanged so the CPU samples stable values while in reset.
  - Next state is RUN if the latched last flag is set, else IDLE.
  - Maximum load throughput is one beat per 2 cycles.
  - Pins keep the last beat's values until the next accept.
- RUN:
  - reset=0 from the first RUN cycle; counter counts RUN_CYCLES cycles.
  - On the last RUN cycle, sample easter_egg into rd_egg; set vout_addr=0; go to SETTLE_S.
- SETTLE_S: hold vout_addr for SETTLE cycles, then capture value_o/is_positive into rd_value/rd_positive; rd_index=vout_addr; rd_last=(vout_addr==all ones); assert rd_valid; go to OUT.
- OUT:
  - rd_valid and all rd_* held stable until rd_ready.
  - On handshake: rd_valid=0. If rd_last, go to DONE; else vout_addr+1 and go to SETTLE_S.
  - rd_ready without rd_valid is ignored.
- DONE:
  - One cycle, done=1.
  - reset returns to 1 at that edge; vout_addr=0.
  - Go to IDLE. rd_egg holds until the next RUN.
- CPU stays running (reset=0) through SETTLE_S/OUT; its outputs are expected static after RUN_CYCLES.
- vout_addr wraps never: the sequence is exactly 0..2**VOUT_W-1.
- ld_last on the very first beat is legal: a one-beat program.

Decomposition:
- Shared package cpu_pad_pkg:
  - state enum: IDLE, HOLD, RUN, SETTLE_S, OUT, DONE
  - ADDR_W/DATA_W/VOUT_W defaults
  - easter_egg width constant
- One sub-module: cpu_pad_cycle_cnt, a loadable down-counter with zero flag, shared by the RUN and SETTLE_S timing.

Test Plan:
- Load 3 beats (reg a=1 b=0x12, reg a=2 b=0x34, data a=5 b=0x7F, last) with ld_valid held -> ld_ready pattern 1,0,1,0,1,0; pins match each beat for 2 cycles; reset=1 throughout; RUN starts the cycle after the third HOLD.
- RUN_CYCLES=64 -> reset low for exactly 64 cycles before vout_addr is first sampled; rd_egg equals the easter_egg value at the last RUN cycle.
- CPU model returns value_o=0x10+vout_addr, is_positive=vout_addr[0], rd_ready=1 -> 4 beats: index 0..3, values 0x10..0x13, rd_last only on index 3, done pulses once, reset=1 next cycle.
- rd_ready low for 10 cycles on beat 1 -> rd_valid/rd_value stable, vout_addr stays 1, no beat lost or duplicated.
- resetn pulsed low during OUT of beat 2 -> all outputs at reset values asynchronously, reset=1; a fresh load afterwards behaves as in the first scenario.
- Single beat with ld_last=1 -> HOLD then RUN directly; SETTLE=1 gives sample one cycle after each vout_addr change.
